// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared types, default constants and mask helper for the range RNG
//   state_t   : FSM encoding (IDLE, SAMPLE)
//   DEF_TAPS  : default Fibonacci tap mask (bits 15,13,12,10)
//   DEF_SEED  : default non-zero reset seed
//   mask_ceil : smallest all-ones mask covering a value (0 -> 0)
package rng_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SAMPLE = 1'b1
  } state_t;

  localparam logic [15:0] DEF_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'hACE1;

  // Smear every set bit downwards so the result is 2^k-1 with 2^k-1 >= v.
  function automatic logic [31:0] mask_ceil(input logic [31:0] v);
    logic [31:0] m;
    m = v;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - free-running Fibonacci LFSR with run-time seeding
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset, loads SEED
//   load     : load load_val this edge (takes priority over stepping)
//   load_val : new seed; zero is replaced by SEED so the register never locks up
//   state    : current LFSR contents
module lfsr_core
  import rng_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_feedback;

  assign w_feedback = ^(r_lfsr & TAPS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (load) begin
      r_lfsr <= (load_val == '0) ? SEED : load_val;
    end else begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_feedback};
    end
  end

  assign state = r_lfsr;

endmodule

// File: rtl/lfsr_range_rng.sv
// rtl/lfsr_range_rng.sv - uniform random number in [0, max_val] by masked rejection sampling
//   clk, rst_n          : clock, synchronous active-low reset
//   seed_load, seed_in  : reseed the LFSR (zero seed replaced by SEED)
//   req, max_val        : request one number with inclusive bound (accepted in IDLE only)
//   busy                : high while sampling
//   valid, rand_out     : one-cycle result strobe; rand_out holds until the next strobe
//   fallback            : result came from folding the last rejected candidate
module lfsr_range_rng
  import rng_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter int                OUT_W     = 4,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEF_SEED),
  parameter int                MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req,
  input  logic [OUT_W-1:0]  max_val,
  output logic              busy,
  output logic              valid,
  output logic [OUT_W-1:0]  rand_out,
  output logic              fallback
);

  localparam int TRIES_W = $clog2(MAX_TRIES) + 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [LFSR_W-1:0]  w_lfsr;
  logic [OUT_W-1:0]   r_max;
  logic [OUT_W-1:0]   r_mask;
  logic [OUT_W-1:0]   r_rand;
  logic [TRIES_W-1:0] r_tries;
  logic               r_valid;
  logic               r_fallback;
  logic [OUT_W-1:0]   w_cand;
  logic [OUT_W-1:0]   w_fold;
  logic               w_accept;
  logic               w_last;
  logic               w_busy;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (w_lfsr)
  );

  assign w_cand   = w_lfsr[OUT_W-1:0] & r_mask;
  assign w_accept = (w_cand <= r_max);
  assign w_last   = (r_tries == TRIES_W'(MAX_TRIES - 1));
  // Only used when w_cand > r_max, so cand - max - 1 never wraps; mask <= 2*max+1
  // keeps the folded value within [0, max].
  assign w_fold   = w_cand - r_max - OUT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req) w_next_state = SAMPLE;
      SAMPLE:  if (w_accept || w_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == SAMPLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_max      <= '0;
      r_mask     <= '0;
      r_tries    <= '0;
      r_rand     <= '0;
      r_valid    <= 1'b0;
      r_fallback <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (req) begin
          r_max   <= max_val;
          r_mask  <= OUT_W'(mask_ceil(32'(max_val)));
          r_tries <= '0;
        end
      end else begin
        if (w_accept) begin
          r_rand     <= w_cand;
          r_fallback <= 1'b0;
          r_valid    <= 1'b1;
        end else if (w_last) begin
          r_rand     <= w_fold;
          r_fallback <= 1'b1;
          r_valid    <= 1'b1;
        end else begin
          r_tries <= r_tries + TRIES_W'(1);
        end
      end
    end
  end

  // A zero LFSR would stall the generator forever; seeding logic must prevent it.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (w_lfsr != '0);
    end
  end

  assign busy     = w_busy;
  assign valid    = r_valid;
  assign rand_out = r_rand;
  assign fallback = r_fallback;

endmodule

// File: tb/tb_lfsr_range_rng.sv
// tb/tb_lfsr_range_rng.sv - self-checking bench for lfsr_range_rng
module tb_lfsr_range_rng;

  localparam int          MAX_TRIES = 8;
  localparam logic [15:0] SEED_C    = 16'hACE1;
  localparam logic [15:0] TAPS_C    = 16'hB400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        req;
  logic [3:0]  max_val;
  logic        busy, valid, fallback;
  logic [3:0]  rand_out;

  logic        b_seed_load;
  logic [15:0] b_seed_in;
  logic        b_req;
  logic [3:0]  b_max_val;
  logic        b_busy, b_valid, b_fallback;
  logic [3:0]  b_rand_out;

  always #5 clk = ~clk;

  lfsr_range_rng #(
    .LFSR_W(16), .OUT_W(4), .TAPS(TAPS_C), .SEED(SEED_C), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .max_val(max_val), .busy(busy), .valid(valid),
    .rand_out(rand_out), .fallback(fallback)
  );

  lfsr_range_rng #(
    .LFSR_W(16), .OUT_W(4), .TAPS(TAPS_C), .SEED(SEED_C), .MAX_TRIES(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .seed_load(b_seed_load), .seed_in(b_seed_in),
    .req(b_req), .max_val(b_max_val), .busy(b_busy), .valid(b_valid),
    .rand_out(b_rand_out), .fallback(b_fallback)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an LFSR sequence plus the list of candidates seen by the open request.
  logic [15:0] m_lfsr;
  bit          m_pending;
  int          m_max, m_mask;
  int          cands[$];
  bit          exp_valid;
  int          exp_rand, exp_fb;
  int          n_accept = 0;
  int          n_valid  = 0;

  function automatic logic [15:0] next_lfsr(input logic [15:0] s);
    int fb;
    fb = $countones(s & TAPS_C) % 2;
    return (s << 1) | 16'(fb);
  endfunction

  function automatic int mask_of(input int v);
    int m;
    m = 0;
    while (m < v) m = m * 2 + 1;
    return m;
  endfunction

  task automatic tick();
    logic [15:0] pre;
    bit          pend;
    int          cand;
    pre  = m_lfsr;
    pend = m_pending;
    @(posedge clk);
    exp_valid = 1'b0;
    if (!rst_n) begin
      m_lfsr    = SEED_C;
      m_pending = 1'b0;
      exp_rand  = 0;
      exp_fb    = 0;
    end else begin
      if (pend) begin
        cand = int'(pre[3:0]) & m_mask;
        cands.push_back(cand);
        if (cand <= m_max) begin
          exp_valid = 1'b1; exp_rand = cand; exp_fb = 0; m_pending = 1'b0;
        end else if (cands.size() == MAX_TRIES) begin
          exp_valid = 1'b1; exp_rand = cand - (m_max + 1); exp_fb = 1; m_pending = 1'b0;
        end
      end else if (req) begin
        m_pending = 1'b1;
        m_max     = int'(max_val);
        m_mask    = mask_of(int'(max_val));
        cands.delete();
        n_accept++;
      end
      m_lfsr = seed_load ? ((seed_in == 16'h0) ? SEED_C : seed_in) : next_lfsr(pre);
    end
    #1;
    chk("busy", 32'(busy), 32'(m_pending));
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("rand_out", 32'(rand_out), 32'(exp_rand));
    chk("fallback", 32'(fallback), 32'(exp_fb));
    chk("lfsr", 32'(dut.u_lfsr.state), 32'(m_lfsr));
    if (valid) n_valid++;
  endtask

  typedef struct {
    logic [15:0] seed;
    logic [3:0]  maxv;
    logic [15:0] lfsr_after;
    int          lat;
    logic [3:0]  r;
    bit          fb;
  } vec_t;

  vec_t vecs[8];
  int   hist[16][16];

  initial begin
    int  lat;
    bit  got;
    int  cur;
    bit  all_hit;

    vecs[0] = '{16'h59C3, 4'd15, 16'h59C3, 1, 4'd3,  1'b0};
    vecs[1] = '{16'h000F, 4'd9,  16'h000F, 4, 4'd8,  1'b0};
    vecs[2] = '{16'h0005, 4'd5,  16'h0005, 1, 4'd5,  1'b0};
    vecs[3] = '{16'h0000, 4'd1,  16'hACE1, 1, 4'd1,  1'b0};
    vecs[4] = '{16'h0006, 4'd4,  16'h0006, 2, 4'd4,  1'b0};
    vecs[5] = '{16'h0007, 4'd2,  16'h0007, 2, 4'd2,  1'b0};
    vecs[6] = '{16'hFFFF, 4'd14, 16'hFFFF, 2, 4'd14, 1'b0};
    vecs[7] = '{16'h0000, 4'd0,  16'hACE1, 1, 4'd0,  1'b0};
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) hist[i][j] = 0;

    m_lfsr = 16'h0; m_pending = 0; exp_rand = 0; exp_fb = 0;
    rst_n = 1'b0; seed_load = 0; seed_in = 0; req = 0; max_val = 0;
    b_seed_load = 0; b_seed_in = 0; b_req = 0; b_max_val = 0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_rand", 32'(rand_out), 0);
    chk("rst_fallback", 32'(fallback), 0);
    chk("rst_lfsr", 32'(dut.u_lfsr.state), 32'h0000ACE1);

    // First request after reset release
    rst_n = 1'b1; req = 1; max_val = 4'd15;
    tick();
    req = 0;
    chk("first_lfsr", 32'(dut.u_lfsr.state), 32'h000059C3);
    chk("first_busy", 32'(busy), 1);
    tick();
    chk("first_valid", 32'(valid), 1);
    chk("first_rand", 32'(rand_out), 3);
    chk("first_fb", 32'(fallback), 0);
    chk("first_busy_done", 32'(busy), 0);
    tick();
    chk("valid_one_cycle", 32'(valid), 0);
    chk("rand_hold", 32'(rand_out), 3);

    // Table: seed + request at the same edge
    foreach (vecs[i]) begin
      seed_load = 1; seed_in = vecs[i].seed; req = 1; max_val = vecs[i].maxv;
      tick();
      seed_load = 0; req = 0;
      chk("vec_lfsr", 32'(dut.u_lfsr.state), 32'(vecs[i].lfsr_after));
      lat = 0; got = 0;
      while (!got && lat < MAX_TRIES + 1) begin
        tick(); lat++;
        if (valid) got = 1;
      end
      chk("vec_done", 32'(got), 1);
      chk("vec_lat", 32'(lat), 32'(vecs[i].lat));
      chk("vec_rand", 32'(rand_out), 32'(vecs[i].r));
      chk("vec_fb", 32'(fallback), 32'(vecs[i].fb));
    end

    // max_val = 0 always yields 0 after one cycle
    for (int n = 0; n < 100; n++) begin
      req = 1; max_val = 0;
      tick();
      req = 0;
      tick();
      chk("zero_valid", 32'(valid), 1);
      chk("zero_rand", 32'(rand_out), 0);
      chk("zero_fb", 32'(fallback), 0);
    end

    // Zero seed is substituted
    seed_load = 1; seed_in = 16'h0;
    tick();
    seed_load = 0;
    chk("zero_seed_lfsr", 32'(dut.u_lfsr.state), 32'h0000ACE1);
    tick();

    // MAX_TRIES=1 build: immediate fallback
    b_seed_load = 1; b_seed_in = 16'h000F; b_req = 1; b_max_val = 4'd9;
    tick();
    b_seed_load = 0; b_req = 0;
    chk("mt1_busy", 32'(b_busy), 1);
    chk("mt1_valid_early", 32'(b_valid), 0);
    tick();
    chk("mt1_valid", 32'(b_valid), 1);
    chk("mt1_rand", 32'(b_rand_out), 5);
    chk("mt1_fb", 32'(b_fallback), 1);
    chk("mt1_busy_done", 32'(b_busy), 0);

    // Reset mid-SAMPLE drops the request
    seed_load = 1; seed_in = 16'h000F; req = 1; max_val = 4'd9;
    tick();
    seed_load = 0; req = 0;
    tick();
    chk("mid_busy", 32'(busy), 1);
    rst_n = 0;
    tick();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_lfsr", 32'(dut.u_lfsr.state), 32'h0000ACE1);
    rst_n = 1;
    got = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (valid) got = 1;
    end
    chk("mid_rst_no_valid", 32'(got), 0);

    // Randomised requests with req held while busy and random reseeding
    n_accept = 0; n_valid = 0;
    for (int n = 0; n < 10000; n++) begin
      cur = $urandom_range(15, 1);
      req = 1; max_val = 4'(cur);
      tick();
      lat = 0; got = 0;
      while (!got && lat < MAX_TRIES + 1) begin
        max_val   = 4'($urandom_range(15, 0));
        seed_load = ($urandom_range(7, 0) == 0);
        seed_in   = ($urandom_range(3, 0) == 0) ? 16'h0 : 16'($urandom);
        tick(); lat++;
        seed_load = 0;
        if (valid) begin
          got = 1;
          hist[cur][rand_out]++;
        end
      end
      chk("rand_latency", 32'(got && (lat <= MAX_TRIES)), 1);
      chk("rand_in_range", 32'(int'(rand_out) <= cur), 1);
    end
    req = 0;
    tick();
    chk("one_valid_per_req", 32'(n_valid), 32'(n_accept));

    for (int m = 1; m < 16; m++) begin
      all_hit = 1;
      for (int v = 0; v <= m; v++) if (hist[m][v] == 0) all_hit = 0;
      chk($sformatf("hist_cover_%0d", m), 32'(all_hit), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_range_rng.md
Name: lfsr_range_rng

Overview:
Parametrised successor to the team's fixed 16-bit/4-bit LFSR generator. It adds run-time seeding, configurable width and taps, and a req/valid handshake. Each delivered number is uniformly distributed in [0, max_val], produced by masked rejection sampling with a bounded retry count. It feeds matrix generation and random operand selection where the value range varies per request (e.g. matrix dimension limits, element ranges).

Parameters:
LFSR_W, 16, LFSR register width (>= OUT_W, >= 4)
OUT_W, 4, width of max_val and rand_out
TAPS, 16'hB400, Fibonacci tap mask; feedback = XOR-reduce(lfsr & TAPS); default taps are bits 15,13,12,10
SEED, 16'hACE1, reset seed and substitute for a zero seed_in; must be non-zero
MAX_TRIES, 8, rejection attempts before fallback (>= 1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
seed_load  input  1  load seed_in into LFSR this edge
seed_in  input  LFSR_W  new seed; zero is replaced by SEED
req  input  1  request one number; sampled only in IDLE
max_val  input  OUT_W  inclusive upper bound, latched on accepted req
busy  output  1  high while in SAMPLE state
valid  output  1  one-cycle pulse, rand_out is valid
rand_out  output  OUT_W  result; holds its value until the next valid
fallback  output  1  qualified by valid; result came from the fold path, not an accepted sample

Behaviour:
- Reset (rst_n low at an edge): lfsr=SEED, state=IDLE, tries=0, valid=0, rand_out=0, fallback=0, busy=0, latched max and mask = 0.
- LFSR free-runs: on every non-reset edge, lfsr <= {lfsr[LFSR_W-2:0], feedback}. When seed_load=1, lfsr <= (seed_in==0 ? SEED : seed_in) instead; seed_load wins over stepping. The all-zero state is unreachable.
- States: IDLE, SAMPLE. busy = (state==SAMPLE), decoded from the state register.
- IDLE, req=1 at an edge: latch max_q=max_val and mask_q = smallest 2^k-1 >= max_val (max_val=0 gives mask 0). Set tries=0, go to SAMPLE. req in SAMPLE is ignored (no queueing).
- SAMPLE, each edge: cand = lfsr[OUT_W-1:0] & mask_q, taken from the pre-edge lfsr.
  - If cand <= max_q: rand_out<=cand, fallback<=0, valid<=1, go to IDLE.
  - Else, if tries==MAX_TRIES-1: rand_out <= cand-(max_q+1), fallback<=1, valid<=1, go to IDLE. The result is always <= max_q because mask_q <= 2*max_q+1.
  - Else: tries++ and stay in SAMPLE.
- valid is high exactly one cycle. Latency from the req edge to valid is 1 cycle minimum and MAX_TRIES cycles maximum. Back-to-back requests: req may be re-asserted in the cycle valid is high, because state is already IDLE.
- seed_load during SAMPLE does not abort the request; later candidates use the reloaded state.
- seed_load and req at the same edge in IDLE: both take effect, and the first candidate is seed_in[OUT_W-1:0] (or SEED's low bits when seed_in is zero).
- Reset mid-SAMPLE: the request is dropped, no valid is issued, and all outputs return to reset values.
- tries width is clog2(MAX_TRIES)+1. All comparisons are unsigned and no arithmetic overflows.

Decomposition:
- Shared package rng_pkg: state enum (IDLE, SAMPLE), default TAPS/SEED constants, mask_ceil function (smear of max_val bits to an all-ones mask).
- One sub-module, lfsr_core: parameters LFSR_W/TAPS/SEED; ports clk, rst_n, load, load_val, state output. It covers stepping, zero-seed substitution and reset.
- lfsr_range_rng instantiates lfsr_core and adds the FSM, latches and output registers.

Test Plan:
- Reset → busy=0, valid=0, rand_out=0, fallback=0, lfsr=0xACE1. After one free edge lfsr=0x59C3.
- Release reset; req=1, max_val=15 at the first edge (lfsr→0x59C3) → next edge: valid=1, rand_out=3, fallback=0, busy low again the cycle valid is high.
- max_val=0, req → after 1 cycle valid=1, rand_out=0. Repeat 100 requests: always 0, never fallback.
- MAX_TRIES=1 build: seed_load=1, seed_in=0x000F, req=1, max_val=9 at the same edge → next edge cand=0xF>9: valid=1, rand_out=5, fallback=1.
- seed_load with seed_in=0 → lfsr=0xACE1, never 0. Reset asserted mid-SAMPLE → no valid pulse, busy=0 the cycle after.
- Random max_val in 1..15 over 10k requests → every rand_out <= max_val, latency <= MAX_TRIES, req held while busy produces exactly one valid per accepted req. Histogram per max_val is flat within ±10%.
